// File: rtl/fb_scaled_reader.sv
// Scales 128x128 display coordinates onto an 80x60 RGB444 buffer and returns RGB565.
// Define FB_SCALED_READER_BGR_EN to pack the output as {b5,g6,r5}.
module fb_scaled_reader #(
   parameter int C_SRC_COLS      = 80,
   parameter int C_SRC_ROWS      = 60,
   parameter int C_DST_SIZE_LOG2 = 7,
   parameter int C_NB_ADDR       = 13,
   parameter int C_RD_LATENCY    = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [C_DST_SIZE_LOG2-1:0] x,
   input  logic [C_DST_SIZE_LOG2-1:0] y,
   input  logic                       next_pixel,
   output logic [C_NB_ADDR-1:0]       rd_addr,
   output logic                       rd_en,
   input  logic [11:0]                rd_data,
   output logic [15:0]                color,
   output logic                       color_valid,
   output logic [7:0]                 frame_cnt,
   output logic                       overrun
);

   localparam int C_W = C_DST_SIZE_LOG2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_WAIT,
      S_LATCH
   } state_t;

   state_t state, state_nxt;

   logic [2*C_W-1:0] last_xy;
   logic [C_W-1:0]   cur_x, cur_y;
   logic [C_W-1:0]   pend_x, pend_y;
   logic             pending;
   logic [1:0]       wait_cnt;

   logic             req;
   logic             ld_cur;
   logic             use_pend;
   logic             store_pend;
   logic             clr_pend;
   logic             set_ovr;
   logic             do_fetch;
   logic             do_latch;
   logic             clr_valid;

   logic [C_NB_ADDR-1:0] addr_calc;
   logic [4:0]           r5, b5;
   logic [5:0]           g6;
   logic [15:0]          color_nxt;

   assign req = next_pixel | ({y, x} != last_xy);

   // Products kept at 32 bits so the shift sees the full value before truncation.
   assign addr_calc = C_NB_ADDR'(
      ((32'(cur_y) * 32'(C_SRC_ROWS)) >> C_DST_SIZE_LOG2) * 32'(C_SRC_COLS) +
      ((32'(cur_x) * 32'(C_SRC_COLS)) >> C_DST_SIZE_LOG2));

   assign r5 = {rd_data[11:8], rd_data[11]};
   assign g6 = {rd_data[7:4], rd_data[7:6]};
   assign b5 = {rd_data[3:0], rd_data[3]};

`ifdef FB_SCALED_READER_BGR_EN
   assign color_nxt = {b5, g6, r5};
`else
   assign color_nxt = {r5, g6, b5};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      ld_cur     = 1'b0;
      use_pend   = 1'b0;
      store_pend = 1'b0;
      clr_pend   = 1'b0;
      set_ovr    = 1'b0;
      do_fetch   = 1'b0;
      do_latch   = 1'b0;
      clr_valid  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (req) begin
               ld_cur    = 1'b1;
               clr_valid = 1'b1;
               state_nxt = S_ADDR;
            end
         end
         S_ADDR: begin
            do_fetch   = 1'b1;
            clr_valid  = 1'b1;
            store_pend = req;
            set_ovr    = req & pending;
            state_nxt  = S_WAIT;
         end
         S_WAIT: begin
            store_pend = req;
            set_ovr    = req & pending;
            if (wait_cnt == 2'd1) begin
               state_nxt = S_LATCH;
            end
         end
         S_LATCH: begin
            do_latch = 1'b1;
            set_ovr  = req & pending;
            // A live request beats the stored one: newest coordinates win.
            if (req) begin
               ld_cur    = 1'b1;
               clr_pend  = 1'b1;
               state_nxt = S_ADDR;
            end else if (pending) begin
               ld_cur    = 1'b1;
               use_pend  = 1'b1;
               clr_pend  = 1'b1;
               state_nxt = S_ADDR;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_xy     <= '1;
         cur_x       <= '0;
         cur_y       <= '0;
         pend_x      <= '0;
         pend_y      <= '0;
         pending     <= 1'b0;
         overrun     <= 1'b0;
         wait_cnt    <= '0;
         rd_addr     <= '0;
         rd_en       <= 1'b0;
         color       <= '0;
         color_valid <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         if (req) begin
            last_xy <= {y, x};
         end
         if (ld_cur) begin
            cur_x <= use_pend ? pend_x : x;
            cur_y <= use_pend ? pend_y : y;
         end
         if (store_pend) begin
            pend_x  <= x;
            pend_y  <= y;
            pending <= 1'b1;
         end else if (clr_pend) begin
            pending <= 1'b0;
         end
         if (set_ovr) begin
            overrun <= 1'b1;
         end
         rd_en <= do_fetch;
         if (do_fetch) begin
            rd_addr  <= addr_calc;
            wait_cnt <= 2'(C_RD_LATENCY);
         end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt - 2'd1;
         end
         if (do_latch) begin
            color       <= color_nxt;
            color_valid <= 1'b1;
         end else if (clr_valid) begin
            color_valid <= 1'b0;
         end
         if (next_pixel && (&x) && (&y)) begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_fb_scaled_reader.sv
// Bench for fb_scaled_reader: one instance at read latency 1, one at latency 2,
// each with its own BRAM model over a shared memory array.
module tb_fb_scaled_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1, rst2, next_pixel;
   logic [6:0]  x, y;
   logic [12:0] rd_addr1, rd_addr2;
   logic        rd_en1, rd_en2;
   logic [11:0] rd_data1, rd_data2;
   logic [15:0] color1, color2;
   logic        cv1, cv2;
   logic [7:0]  fc1, fc2;
   logic        ov1, ov2;

   fb_scaled_reader #(.C_RD_LATENCY(1)) dut1 (
      .clk(clk), .reset(rst1), .x(x), .y(y), .next_pixel(next_pixel),
      .rd_addr(rd_addr1), .rd_en(rd_en1), .rd_data(rd_data1),
      .color(color1), .color_valid(cv1), .frame_cnt(fc1), .overrun(ov1));

   fb_scaled_reader #(.C_RD_LATENCY(2)) dut2 (
      .clk(clk), .reset(rst2), .x(x), .y(y), .next_pixel(next_pixel),
      .rd_addr(rd_addr2), .rd_en(rd_en2), .rd_data(rd_data2),
      .color(color2), .color_valid(cv2), .frame_cnt(fc2), .overrun(ov2));

   logic [11:0] mem [0:8191];
   logic [11:0] p2 = '0;
   int          fetch1 = 0, fetch2 = 0;
   logic [12:0] last1 = '0, last2 = '0;

   always @(posedge clk) begin
      if (rd_en1) begin
         rd_data1 <= mem[rd_addr1];
         fetch1   <= fetch1 + 1;
         last1    <= rd_addr1;
      end
      if (rd_en2) begin
         p2     <= mem[rd_addr2];
         fetch2 <= fetch2 + 1;
         last2  <= rd_addr2;
      end
      rd_data2 <= p2;
   end

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic int map_addr(input int cx, input int cy);
      return (cy * 60 / 128) * 80 + (cx * 80 / 128);
   endfunction

   function automatic int expand(input int d);
      int r, g, b, r5, g6, b5;
      r  = d / 256;
      g  = (d / 16) % 16;
      b  = d % 16;
      r5 = r * 2 + r / 8;
      g6 = g * 4 + g / 4;
      b5 = b * 2 + b / 8;
`ifdef FB_SCALED_READER_BGR_EN
      return b5 * 2048 + g6 * 32 + r5;
`else
      return r5 * 2048 + g6 * 32 + b5;
`endif
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_both(input string tag, input int f1, input int f2,
                           input int nf, input int a, input int c);
      chk({tag, " fetches1"}, fetch1 - f1, nf);
      chk({tag, " fetches2"}, fetch2 - f2, nf);
      chk({tag, " addr1"}, int'(last1), a);
      chk({tag, " addr2"}, int'(last2), a);
      chk({tag, " color1"}, int'(color1), c);
      chk({tag, " color2"}, int'(color2), c);
      chk({tag, " valid1"}, int'(cv1), 1);
      chk({tag, " valid2"}, int'(cv2), 1);
   endtask

   typedef struct {
      logic [6:0]  vx, vy;
      logic [11:0] d;
      int          a;
      logic [15:0] rgb, bgr;
   } vec_t;

   vec_t tbl[6];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int f1, f2, exp_frames, ec, a;
      logic [6:0] nx, ny;
      logic np;
      bit en1_t, cv1_t, en2_t, cv2_t;

      tbl[0] = '{7'd127, 7'd127, 12'h0F0, 4799, 16'h07E0, 16'h07E0};
      tbl[1] = '{7'd64,  7'd64,  12'h00F, 2440, 16'h001F, 16'hF800};
      tbl[2] = '{7'd2,   7'd3,   12'h842, 81,   16'h8A24, 16'h2231};
      tbl[3] = '{7'd100, 7'd10,  12'hFFF, 382,  16'hFFFF, 16'hFFFF};
      tbl[4] = '{7'd127, 7'd0,   12'h000, 79,   16'h0000, 16'h0000};
      tbl[5] = '{7'd0,   7'd0,   12'hF00, 0,    16'hF800, 16'h001F};

      for (int i = 0; i < 8192; i++) mem[i] = 12'h0;
      exp_frames = 0;
      mem[0] = 12'hF00;
      rst1 = 1'b1; rst2 = 1'b1; next_pixel = 1'b0; x = 7'd0; y = 7'd0;
      cyc(3);
      chk("rst rd_addr", int'(rd_addr1), 0);
      chk("rst rd_en", int'(rd_en1), 0);
      chk("rst color", int'(color1), 0);
      chk("rst valid", int'(cv1), 0);
      chk("rst frame", int'(fc1), 0);
      chk("rst overrun", int'(ov1), 0);
      chk("rst color2", int'(color2), 0);
      chk("rst valid2", int'(cv2), 0);

      // Release reset: (0,0) differs from the reset last_xy, so a fetch starts.
      f1 = fetch1; f2 = fetch2;
      rst1 = 1'b0; rst2 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         cyc(1);
         en1_t = (k == 2); cv1_t = (k >= 4);
         en2_t = (k == 2); cv2_t = (k >= 5);
         chk($sformatf("lat rd_en1 c%0d", k), int'(rd_en1), int'(en1_t));
         chk($sformatf("lat valid1 c%0d", k), int'(cv1), int'(cv1_t));
         chk($sformatf("lat rd_en2 c%0d", k), int'(rd_en2), int'(en2_t));
         chk($sformatf("lat valid2 c%0d", k), int'(cv2), int'(cv2_t));
      end
      chk_both("first", f1, f2, 1, 0, expand(12'hF00));

      foreach (tbl[i]) begin
         f1 = fetch1; f2 = fetch2;
         mem[tbl[i].a] = tbl[i].d;
         x = tbl[i].vx; y = tbl[i].vy;
         cyc(8);
`ifdef FB_SCALED_READER_BGR_EN
         ec = int'(tbl[i].bgr);
`else
         ec = int'(tbl[i].rgb);
`endif
         chk_both($sformatf("tbl%0d", i), f1, f2, 1, tbl[i].a, ec);
      end

      // Frame counter: move to the last pixel, then consume it.
      x = 7'd127; y = 7'd127;
      cyc(8);
      chk("frame pre", int'(fc1), exp_frames);
      f1 = fetch1; f2 = fetch2;
      next_pixel = 1'b1;
      cyc(1);
      next_pixel = 1'b0;
      exp_frames++;
      cyc(8);
      chk("frame post1", int'(fc1), exp_frames);
      chk("frame post2", int'(fc2), exp_frames);
      chk_both("frame refetch", f1, f2, 1, 4799, expand(int'(mem[4799])));

      for (int i = 0; i < 400; i++) begin
         nx = ($urandom_range(0, 7) == 0) ? 7'd127 : 7'($urandom_range(0, 127));
         ny = ($urandom_range(0, 7) == 0) ? 7'd127 : 7'($urandom_range(0, 127));
         np = ($urandom_range(0, 3) == 0);
         if (nx == x && ny == y) np = 1'b1;
         if (np && nx == 7'd127 && ny == 7'd127) exp_frames++;
         a = map_addr(int'(nx), int'(ny));
         mem[a] = 12'($urandom);
         f1 = fetch1; f2 = fetch2;
         x = nx; y = ny; next_pixel = np;
         cyc(1);
         next_pixel = 1'b0;
         cyc(7);
         chk_both($sformatf("rnd%0d", i), f1, f2, 1, a, expand(int'(mem[a])));
      end
      chk("rnd frame1", int'(fc1), exp_frames % 256);
      chk("rnd frame2", int'(fc2), exp_frames % 256);
      chk("rnd overrun1", int'(ov1), 0);
      chk("rnd overrun2", int'(ov2), 0);

      // Burst of coordinate changes while a fetch is in flight.
      x = 7'd5; y = 7'd5; next_pixel = 1'b1;
      cyc(1);
      next_pixel = 1'b0;
      cyc(8);
      mem[map_addr(10, 10)] = 12'h111;
      mem[map_addr(20, 20)] = 12'h222;
      mem[map_addr(30, 30)] = 12'h333;
      mem[map_addr(40, 50)] = 12'h9C5;
      f1 = fetch1; f2 = fetch2;
      x = 7'd10; y = 7'd10; cyc(1);
      x = 7'd20; y = 7'd20; cyc(1);
      x = 7'd30; y = 7'd30; cyc(1);
      x = 7'd40; y = 7'd50; cyc(12);
      chk_both("burst", f1, f2, 2, map_addr(40, 50), expand(12'h9C5));
      chk("burst overrun1", int'(ov1), 1);
      chk("burst overrun2", int'(ov2), 1);

      // Reset the latency-2 instance while its fetch waits on the BRAM.
      a = map_addr(60, 60);
      mem[a] = 12'hABC;
      f2 = fetch2;
      x = 7'd60; y = 7'd60;
      cyc(2);
      chk("midrst rd_en2", int'(rd_en2), 1);
      rst2 = 1'b1;
      cyc(1);
      chk("midrst color2", int'(color2), 0);
      chk("midrst valid2", int'(cv2), 0);
      rst2 = 1'b0; x = 7'd127; y = 7'd127;
      cyc(8);
      chk("post color2", int'(color2), 0);
      chk("post valid2", int'(cv2), 0);
      chk("post fetches2", fetch2 - f2, 1);
      chk("post overrun2", int'(ov2), 0);
      chk("post frame2", int'(fc2), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
